// File: rtl/ide_reset_sequencer_if.sv
// Reset-sequencer signal bundle: per-channel requests in, per-channel
// reset outputs and status out. The optional software pulse input exists
// only when IDE_RESET_SWPULSE_EN is defined.
interface ide_reset_sequencer_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] rst_req;
  logic [CHANNELS-1:0] rst_out;
  logic [CHANNELS-1:0] busy;
  logic                all_ready;
`ifdef IDE_RESET_SWPULSE_EN
  logic [CHANNELS-1:0] sw_pulse;

  modport master (
    output rst_req,
    output sw_pulse,
    input  rst_out,
    input  busy,
    input  all_ready
  );

  modport slave (
    input  rst_req,
    input  sw_pulse,
    output rst_out,
    output busy,
    output all_ready
  );
`else
  modport master (
    output rst_req,
    input  rst_out,
    input  busy,
    input  all_ready
  );

  modport slave (
    input  rst_req,
    output rst_out,
    output busy,
    output all_ready
  );
`endif
endinterface

// File: rtl/ide_reset_sequencer.sv
// Per-channel drive reset sequencer with debounced assert and release.
// Each channel runs its own FSM; a request must be stable for ASSERT_DLY
// cycles before rst_out asserts, and absent for RELEASE_DLY + i*STAGGER
// cycles before it releases. Any reversal during a pending phase cancels it.
// Optional feature macro: IDE_RESET_SWPULSE_EN adds sw_pulse, which forces a
// channel straight into RESET on the next edge.
//
// state           | meaning
// ST_RUN          | drive out of reset, waiting for a request
// ST_ASSERT_PEND  | request seen, counting toward assertion (output still released)
// ST_RESET        | drive held in reset
// ST_RELEASE_PEND | request gone, counting toward release (output still asserted)
module ide_reset_sequencer #(
  parameter int          CHANNELS       = 2,
  parameter int          CNT_W          = 21,
  parameter int unsigned ASSERT_DLY     = 21'h000300,
  parameter int unsigned RELEASE_DLY    = 21'h150000,
  parameter int unsigned STAGGER        = 0,
  parameter bit          OUT_ACTIVE_LOW = 1
) (
  input logic                  clk,
  input logic                  rst,
  ide_reset_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_ASSERT_PEND  = 2'd1,
    ST_RESET        = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } state_t;

  localparam longint unsigned MAX_CNT = (64'd1 << CNT_W) - 64'd1;

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_err_channels
    $error("ide_reset_sequencer: CHANNELS must be 1..8");
  end
  if (ASSERT_DLY < 1 || RELEASE_DLY < 1) begin : g_err_min_dly
    $error("ide_reset_sequencer: delays must be at least 1");
  end
  if (longint'(ASSERT_DLY) > MAX_CNT) begin : g_err_assert_dly
    $error("ide_reset_sequencer: ASSERT_DLY does not fit in CNT_W bits");
  end

  logic [CHANNELS-1:0] asrt_vec;
  logic [CHANNELS-1:0] busy_vec;
  logic [CHANNELS-1:0] run_next;
  logic                all_ready_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam longint unsigned REL_L =
      longint'(RELEASE_DLY) + longint'(i) * longint'(STAGGER);

    if (REL_L > MAX_CNT) begin : g_err_release_dly
      $error("ide_reset_sequencer: release delay does not fit in CNT_W bits");
    end

    // Terminal counts: the transition fires on the edge where the counter
    // would reach the delay, giving exactly DLY cycles from first sample.
    localparam logic [CNT_W-1:0] ASR_LAST = CNT_W'(longint'(ASSERT_DLY) - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_L - 1);

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             asrt_q, busy_q;
    logic             req;

    assign req = bus.rst_req[i];

    // Next-state and counter logic for this channel.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
        ST_RUN: begin
          if (req) begin
            st_d  = ST_ASSERT_PEND;
            cnt_d = '0;
          end
        end
        ST_ASSERT_PEND: begin
          if (!req) begin
            st_d  = ST_RUN;
            cnt_d = '0;
          end else if (cnt_q >= ASR_LAST) begin
            st_d  = ST_RESET;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RESET: begin
          if (!req) begin
            st_d  = ST_RELEASE_PEND;
            cnt_d = '0;
          end
        end
        ST_RELEASE_PEND: begin
          if (req) begin
            st_d  = ST_RESET;
            cnt_d = '0;
          end else if (cnt_q >= REL_LAST) begin
            st_d  = ST_RUN;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          st_d  = ST_RESET;
          cnt_d = '0;
        end
      endcase
`ifdef IDE_RESET_SWPULSE_EN
      if (bus.sw_pulse[i]) begin
        st_d  = ST_RESET;
        cnt_d = '0;
      end
`endif
    end

    // State, counter and registered per-channel outputs, all from next state
    // so outputs always agree with the state of the same cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= ST_RESET;
        cnt_q  <= '0;
        asrt_q <= 1'b1;
        busy_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        asrt_q <= (st_d == ST_RESET) || (st_d == ST_RELEASE_PEND);
        busy_q <= (st_d == ST_ASSERT_PEND) || (st_d == ST_RELEASE_PEND);
      end
    end

    assign asrt_vec[i] = asrt_q;
    assign busy_vec[i] = busy_q;
    assign run_next[i] = (st_d == ST_RUN);
  end

  // Global ready flag, registered alongside the channel states.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_ready_q <= 1'b0;
    end else begin
      all_ready_q <= &run_next;
    end
  end

  assign bus.rst_out   = asrt_vec ^ {CHANNELS{OUT_ACTIVE_LOW}};
  assign bus.busy      = busy_vec;
  assign bus.all_ready = all_ready_q;

endmodule
